// File: rtl/sync_event_capture_if.sv
// sync_event_capture_if: valid/ready event channel carrying channel index, edge type and timestamp
interface sync_event_capture_if #(
    parameter int CW   = 3,
    parameter int TS_W = 16
);
    logic            evt_valid;
    logic            evt_ready;
    logic [CW-1:0]   evt_chan;
    logic            evt_edge;
    logic [TS_W-1:0] evt_ts;
    modport master (output evt_valid, evt_chan, evt_edge, evt_ts, input evt_ready);
    modport slave  (input evt_valid, evt_chan, evt_edge, evt_ts, output evt_ready);
endinterface

// File: rtl/sync_event_capture.sv
// sync_event_capture: synchronizes async inputs, timestamps mode-selected edges and drains them round-robin
module sync_event_capture #(
    parameter int CHANNELS = 8,
    parameter int STAGES   = 2,
    parameter int TS_W     = 16,
    localparam int CW      = $clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [CHANNELS-1:0]     async_in,
    input  logic [2*CHANNELS-1:0]   mode,
    output logic [CHANNELS-1:0]     level_out,
    output logic [CHANNELS-1:0]     overflow,
    input  logic                    ovf_clear,
    sync_event_capture_if.master    evt
);
    logic [STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]             prev, rise, fall, hit, pend, pend_edge, gnt, drop;
    logic [CHANNELS-1:0][TS_W-1:0]   pend_ts;
    logic [TS_W-1:0]                 ts;
    logic [CW-1:0]                   ptr, sel;
    logic                            found, load;
    int                              j;

    assign level_out = sync_q[STAGES-1];
    assign rise      = level_out & ~prev;
    assign fall      = ~level_out & prev;
    assign load      = !evt.evt_valid || evt.evt_ready;
    assign gnt       = (load && found) ? (CHANNELS'(1) << sel) : '0;
    assign drop      = hit & pend & ~gnt;

    // an edge qualifies only while enabled and selected by its channel's mode bits
    always_comb begin
        hit = '0;
        for (int i = 0; i < CHANNELS; i++)
            hit[i] = ena && ((rise[i] && mode[2*i]) || (fall[i] && mode[2*i+1]));
    end

    // round-robin search from ptr; walking offsets downward lets the nearest pending channel win
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int k = CHANNELS-1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= CHANNELS) j = j - CHANNELS;
            if (pend[j]) begin
                found = 1'b1;
                sel   = CW'(j);
            end
        end
    end

    // synchronizer chain, previous-level register and free-running timestamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= '0;
            ts     <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev   <= level_out;
            if (ena) ts <= ts + 1'b1;
        end
    end

    // pending slots: a same-cycle grant frees the slot so a new event can replace it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            pend_edge <= '0;
            pend_ts   <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i] && (!pend[i] || gnt[i])) begin
                    pend[i]      <= 1'b1;
                    pend_edge[i] <= rise[i];
                    pend_ts[i]   <= ts;
                end else if (gnt[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // sticky drop flags; a coincident drop overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= '0;
        else     overflow <= (ovf_clear ? '0 : overflow) | drop;
    end

    // output register and round-robin pointer advance on each grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_chan  <= '0;
            evt.evt_edge  <= 1'b0;
            evt.evt_ts    <= '0;
            ptr           <= '0;
        end else if (load) begin
            evt.evt_valid <= found;
            if (found) begin
                evt.evt_chan <= sel;
                evt.evt_edge <= pend_edge[sel];
                evt.evt_ts   <= pend_ts[sel];
                ptr          <= (sel == CW'(CHANNELS-1)) ? '0 : sel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_event_capture.sv
// tb_sync_event_capture: directed and random stimulus against a queue-based reference model with scoreboard
module tb_sync_event_capture;
    localparam int CH = 8;
    localparam int ST = 2;
    localparam int TW = 4;
    localparam int CW = $clog2(CH);

    typedef struct packed {
        logic [CW-1:0] c;
        logic          e;
        logic [TW-1:0] t;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ena = 1'b0;
    logic            ovf_clear = 1'b0;
    logic [CH-1:0]   async_in = '0;
    logic [2*CH-1:0] mode = '0;
    logic [CH-1:0]   level_out, overflow;

    sync_event_capture_if #(.CW(CW), .TS_W(TW)) evt_if();

    sync_event_capture #(.CHANNELS(CH), .STAGES(ST), .TS_W(TW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .async_in(async_in), .mode(mode),
        .level_out(level_out), .overflow(overflow), .ovf_clear(ovf_clear), .evt(evt_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference model: event stream derived from delayed samples, per-channel slots and a modular counter
    ev_t           exp_q[$];
    logic [CH-1:0] dly[$];
    bit [CH-1:0]   m_pend, m_edge, m_ovf, m_cur, m_prv, m_hit, m_drop;
    int            m_ts[CH];
    bit            m_valid;
    int            m_ptr, m_cnt, m_c;
    ev_t           m_x;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0; m_edge = '0; m_ovf = '0; m_cur = '0; m_prv = '0;
            m_valid = 0; m_ptr = 0; m_cnt = 0;
            exp_q.delete();
            dly.delete();
            for (int k = 0; k < ST-1; k++) dly.push_back('0);
        end else begin
            m_hit = '0;
            for (int i = 0; i < CH; i++)
                if (ena && ((m_cur[i] && !m_prv[i] && mode[2*i]) || (!m_cur[i] && m_prv[i] && mode[2*i+1])))
                    m_hit[i] = 1;
            if (!m_valid || evt_if.evt_ready) begin
                m_valid = 0;
                for (int k = 0; k < CH; k++) begin
                    m_c = (m_ptr + k) % CH;
                    if (!m_valid && m_pend[m_c]) begin
                        m_valid = 1;
                        m_x.c = CW'(m_c);
                        m_x.e = m_edge[m_c];
                        m_x.t = TW'(m_ts[m_c]);
                        exp_q.push_back(m_x);
                        m_pend[m_c] = 0;
                        m_ptr = (m_c + 1) % CH;
                    end
                end
            end
            m_drop = '0;
            for (int i = 0; i < CH; i++)
                if (m_hit[i]) begin
                    if (m_pend[i]) m_drop[i] = 1;
                    else begin
                        m_pend[i] = 1;
                        m_edge[i] = m_cur[i];
                        m_ts[i]   = m_cnt;
                    end
                end
            m_ovf = (ovf_clear ? '0 : m_ovf) | m_drop;
            if (ena) m_cnt = (m_cnt + 1) % (1 << TW);
            dly.push_back(async_in);
            m_prv = m_cur;
            m_cur = dly.pop_front();
        end
    end

    // monitor: compares presented events against the scoreboard and pops on transfer
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", 32'(evt_if.evt_valid), 32'(m_valid));
            chk("level", 32'(level_out), 32'(m_cur));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (evt_if.evt_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL event: unexpected chan=%0d with empty scoreboard at %0t", evt_if.evt_chan, $time);
                end else begin
                    chk("chan", 32'(evt_if.evt_chan), 32'(exp_q[0].c));
                    chk("edge", 32'(evt_if.evt_edge), 32'(exp_q[0].e));
                    chk("ts", 32'(evt_if.evt_ts), 32'(exp_q[0].t));
                    if (evt_if.evt_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        ena = 1'b1;
        mode = 16'h5555;
        // single event: counter reaches 5, then channel 0 rises
        cyc(5);
        async_in[0] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("single_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("single_chan", 32'(evt_if.evt_chan), 32'd0);
        chk("single_edge", 32'(evt_if.evt_edge), 32'd1);
        chk("single_ts", 32'(evt_if.evt_ts), 32'd7);
        // arbitration under backpressure
        cyc(1);
        evt_if.evt_ready = 1'b0;
        async_in[1] = 1'b1; async_in[2] = 1'b1; async_in[5] = 1'b1;
        cyc(8);
        @(negedge clk);
        chk("stall_chan", 32'(evt_if.evt_chan), 32'd1);
        cyc(1);
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        chk("arb_first", 32'(evt_if.evt_chan), 32'd1);
        @(negedge clk);
        chk("arb_second", 32'(evt_if.evt_chan), 32'd2);
        @(negedge clk);
        chk("arb_third", 32'(evt_if.evt_chan), 32'd5);
        chk("arb_no_ovf", 32'(overflow), 32'd0);
        // reset while one event is presented and two are pending
        cyc(1);
        async_in = '0;
        cyc(6);
        evt_if.evt_ready = 1'b0;
        async_in[3] = 1'b1; async_in[4] = 1'b1; async_in[6] = 1'b1;
        cyc(7);
        @(negedge clk);
        chk("pre_rst_valid", 32'(evt_if.evt_valid), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("rst_chan", 32'(evt_if.evt_chan), 32'd0);
        chk("rst_edge", 32'(evt_if.evt_edge), 32'd0);
        chk("rst_ts", 32'(evt_if.evt_ts), 32'd0);
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        async_in = '0;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        @(negedge clk);
        chk("post_rst_idle", 32'(evt_if.evt_valid), 32'd0);
        // overflow on channel 4 with both-edge mode and the consumer stalled
        cyc(1);
        mode = 16'h0300;
        async_in[4] = 1'b1;
        cyc(4);
        async_in[4] = 1'b0;
        cyc(4);
        async_in[4] = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("ovf_set", 32'(overflow[4]), 32'd1);
        chk("ovf_kept_edge", 32'(evt_if.evt_edge), 32'd1);
        chk("ovf_kept_chan", 32'(evt_if.evt_chan), 32'd4);
        cyc(1);
        ovf_clear = 1'b1;
        cyc(1);
        ovf_clear = 1'b0;
        @(negedge clk);
        chk("ovf_clear", 32'(overflow[4]), 32'd0);
        cyc(1);
        evt_if.evt_ready = 1'b1;
        cyc(6);
        // random phase with occasional enable drops, mode changes and clears
        repeat (3000) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 11) == 0) async_in[i] = ~async_in[i];
            if ($urandom_range(0, 99) == 0) mode = 16'($urandom);
            ena = $urandom_range(0, 7) != 0;
            evt_if.evt_ready = $urandom_range(0, 3) != 0;
            ovf_clear = $urandom_range(0, 19) == 0;
            cyc(1);
        end
        ena = 1'b0;
        repeat (40) begin
            async_in = CH'($urandom);
            cyc(1);
        end
        evt_if.evt_ready = 1'b1;
        ovf_clear = 1'b0;
        cyc(20);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
